// File: rtl/bp_pkg.sv
// Shared types, widths and counter encodings for the fetch branch predictor.
package bp_pkg;

  localparam int BP_XLEN     = 32;
  localparam int BP_ENTRIES  = 16;
  localparam int BP_CTR_BITS = 2;

  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int tag_w(input int xlen, input int entries);
    return xlen - $clog2(entries) - 2;
  endfunction

  function automatic int ctr_weak_t(input int w);
    return 1 << (w - 1);
  endfunction

  function automatic int ctr_weak_nt(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int ctr_max(input int w);
    return (1 << w) - 1;
  endfunction

  localparam logic [BP_CTR_BITS-1:0] CTR_WEAK_T  = BP_CTR_BITS'(ctr_weak_t(BP_CTR_BITS));
  localparam logic [BP_CTR_BITS-1:0] CTR_WEAK_NT = BP_CTR_BITS'(ctr_weak_nt(BP_CTR_BITS));
  localparam logic [BP_CTR_BITS-1:0] CTR_MAX     = BP_CTR_BITS'(ctr_max(BP_CTR_BITS));

  // Full entry layout for the default geometry (trace/debug views use this).
  typedef struct packed {
    logic                                     valid;
    logic [tag_w(BP_XLEN, BP_ENTRIES)-1:0]    tag;
    logic [BP_XLEN-1:0]                       target;
    logic [BP_CTR_BITS-1:0]                   ctr;
  } btb_entry_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter with synchronous clear and load.
module sat_counter #(
  parameter int            W       = 2,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  logic [W-1:0]  load_val,
  input  logic          inc,
  input  logic          dec,
  output logic [W-1:0]  q
);

  logic [W-1:0] cnt_q, cnt_d;

  // clr beats load beats inc/dec; simultaneous inc and dec cancel.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                                  cnt_d = '0;
    else if (load)                            cnt_d = load_val;
    else if (inc && !dec && (cnt_q != '1))    cnt_d = cnt_q + W'(1);
    else if (dec && !inc && (cnt_q != '0))    cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= RST_VAL;
    else     cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry direction counters, Execute-stage
// mispredict/redirect generation, and saturating performance counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  i_pcF,
  output logic             o_PredTakenF,
  output logic [XLEN-1:0]  o_PredPcF,
  input  logic             i_UpdateE,
  input  logic             i_IsJumpE,
  input  logic [XLEN-1:0]  i_pcE,
  input  logic             i_TakenE,
  input  logic [XLEN-1:0]  i_TargetE,
  input  logic             i_PredTakenE,
  input  logic [XLEN-1:0]  i_PredPcE,
  output logic             o_MispredictE,
  output logic [XLEN-1:0]  o_RedirectPcE,
  input  logic             i_CntClr,
  output logic [CNT_W-1:0] o_BranchCnt,
  output logic [CNT_W-1:0] o_MispredCnt
);

  localparam int IDX  = idx_w(ENTRIES);
  localparam int TAGW = tag_w(XLEN, ENTRIES);
  localparam logic [CTR_BITS-1:0] WEAK_T  = CTR_BITS'(ctr_weak_t(CTR_BITS));
  localparam logic [CTR_BITS-1:0] WEAK_NT = CTR_BITS'(ctr_weak_nt(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CMAX    = CTR_BITS'(ctr_max(CTR_BITS));

  typedef struct packed {
    logic            valid;
    logic [TAGW-1:0] tag;
    logic [XLEN-1:0] target;
  } meta_t;

  meta_t meta_q [ENTRIES];
  meta_t meta_d [ENTRIES];

  logic [ENTRIES-1:0][CTR_BITS-1:0] ctr;
  logic [ENTRIES-1:0]               ctr_load, ctr_inc, ctr_dec;
  logic [CTR_BITS-1:0]              ctr_load_val;

  logic [IDX-1:0]  idx_f, idx_e;
  logic [TAGW-1:0] tag_f, tag_e;
  logic            hit_f, hit_e;

  assign idx_f = i_pcF[IDX+1:2];
  assign tag_f = i_pcF[XLEN-1:IDX+2];
  assign idx_e = i_pcE[IDX+1:2];
  assign tag_e = i_pcE[XLEN-1:IDX+2];

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign hit_f         = meta_q[idx_f].valid && (meta_q[idx_f].tag == tag_f);
  assign o_PredTakenF  = hit_f && ctr[idx_f][CTR_BITS-1];
  assign o_PredPcF     = o_PredTakenF ? meta_q[idx_f].target : i_pcF + XLEN'(4);

  assign hit_e         = meta_q[idx_e].valid && (meta_q[idx_e].tag == tag_e);
  assign o_MispredictE = i_UpdateE && (i_TakenE ? (i_PredPcE != i_TargetE) : i_PredTakenE);
  assign o_RedirectPcE = i_TakenE ? i_TargetE : i_pcE + XLEN'(4);

  always_comb begin
    meta_d       = meta_q;
    ctr_load     = '0;
    ctr_inc      = '0;
    ctr_dec      = '0;
    ctr_load_val = WEAK_T;
    if (i_UpdateE) begin
      if (i_IsJumpE && i_TakenE) begin
        meta_d[idx_e]   = '{valid: 1'b1, tag: tag_e, target: i_TargetE};
        ctr_load[idx_e] = 1'b1;
        ctr_load_val    = CMAX;
      end else if (i_TakenE) begin
        if (hit_e) begin
          meta_d[idx_e].target = i_TargetE;
          ctr_inc[idx_e]       = 1'b1;
        end else begin
          meta_d[idx_e]   = '{valid: 1'b1, tag: tag_e, target: i_TargetE};
          ctr_load[idx_e] = 1'b1;
        end
      end else if (hit_e) begin
        // Not-taken misses are deliberately not allocated.
        ctr_dec[idx_e] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) meta_q[i] <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) meta_q[i] <= meta_d[i];
    end
  end

  for (genvar e = 0; e < ENTRIES; e++) begin : g_ctr
    sat_counter #(.W(CTR_BITS), .RST_VAL(WEAK_NT)) u_ctr (
      .clk      (clk),
      .rst      (rst),
      .clr      (1'b0),
      .load     (ctr_load[e]),
      .load_val (ctr_load_val),
      .inc      (ctr_inc[e]),
      .dec      (ctr_dec[e]),
      .q        (ctr[e])
    );
  end

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (i_CntClr),
    .load     (1'b0),
    .load_val ({CNT_W{1'b0}}),
    .inc      (i_UpdateE),
    .dec      (1'b0),
    .q        (o_BranchCnt)
  );

  sat_counter #(.W(CNT_W)) u_mispred_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (i_CntClr),
    .load     (1'b0),
    .load_val ({CNT_W{1'b0}}),
    .inc      (o_MispredictE),
    .dec      (1'b0),
    .q        (o_MispredCnt)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: table of update/lookup vectors plus hand-written counter and reset sequences.
module tb_branch_predictor;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk, rst;
  logic [XLEN-1:0]  pcF, pcE, tgtE, ppcE;
  logic             upd, jmp, tkn, ptkn, cnt_clr;
  logic             pred_taken_f, mispred_e;
  logic [XLEN-1:0]  pred_pc_f, redirect_pc_e;
  logic [CNT_W-1:0] branch_cnt, mispred_cnt;

  branch_predictor #(.XLEN(XLEN), .ENTRIES(16), .CTR_BITS(2), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_pcF        (pcF),
    .o_PredTakenF (pred_taken_f),
    .o_PredPcF    (pred_pc_f),
    .i_UpdateE    (upd),
    .i_IsJumpE    (jmp),
    .i_pcE        (pcE),
    .i_TakenE     (tkn),
    .i_TargetE    (tgtE),
    .i_PredTakenE (ptkn),
    .i_PredPcE    (ppcE),
    .o_MispredictE(mispred_e),
    .o_RedirectPcE(redirect_pc_e),
    .i_CntClr     (cnt_clr),
    .o_BranchCnt  (branch_cnt),
    .o_MispredCnt (mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        upd, jmp;
    logic [31:0] pc_e;
    logic        tkn;
    logic [31:0] tgt;
    logic        ptkn;
    logic [31:0] ppc, pc_f;
    logic        e_pt;
    logic [31:0] e_ppc;
    logic        e_mis;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t vecs[$];
  int   n_pass, n_total;

  function automatic vec_t mk(logic u, logic j, logic [31:0] pe, logic t, logic [31:0] tg,
                              logic pt, logic [31:0] pp, logic [31:0] pf, logic ept,
                              logic [31:0] eppc, logic emis, logic [31:0] erpc);
    vec_t v;
    v.upd = u; v.jmp = j; v.pc_e = pe; v.tkn = t; v.tgt = tg; v.ptkn = pt; v.ppc = pp;
    v.pc_f = pf; v.e_pt = ept; v.e_ppc = eppc; v.e_mis = emis; v.e_rpc = erpc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic drive(input logic u, input logic j, input logic [31:0] pe, input logic t,
                       input logic [31:0] tg, input logic pt, input logic [31:0] pp,
                       input logic [31:0] pf);
    upd = u; jmp = j; pcE = pe; tkn = t; tgtE = tg; ptkn = pt; ppcE = pp; pcF = pf;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h100);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    cnt_clr = 1'b0;
    rst = 1'b1;
    idle();

    //      upd jmp pcE     tkn tgt     ptkn ppc     pcF          ePT ePPC        eMis eRPC
    vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h100, 0, 32'h104, 0, 32'h4));
    vecs.push_back(mk(1, 0, 32'h100, 1, 32'h80,  0, 32'h104, 32'h100, 0, 32'h104, 1, 32'h80));
    vecs.push_back(mk(0, 0, 32'h100, 0, 32'h0,   0, 32'h0,   32'h100, 1, 32'h80,  0, 32'h104));
    vecs.push_back(mk(1, 0, 32'h100, 0, 32'h0,   1, 32'h80,  32'h100, 1, 32'h80,  1, 32'h104));
    vecs.push_back(mk(1, 0, 32'h100, 0, 32'h0,   0, 32'h104, 32'h100, 0, 32'h104, 0, 32'h104));
    vecs.push_back(mk(1, 0, 32'h100, 0, 32'h0,   0, 32'h104, 32'h100, 0, 32'h104, 0, 32'h104));
    vecs.push_back(mk(1, 0, 32'h100, 1, 32'h80,  0, 32'h104, 32'h100, 0, 32'h104, 1, 32'h80));
    vecs.push_back(mk(0, 0, 32'h100, 0, 32'h0,   0, 32'h0,   32'h100, 0, 32'h104, 0, 32'h104));
    vecs.push_back(mk(1, 0, 32'h100, 1, 32'h80,  0, 32'h104, 32'h100, 0, 32'h104, 1, 32'h80));
    vecs.push_back(mk(1, 1, 32'h140, 1, 32'h200, 0, 32'h144, 32'h100, 1, 32'h80,  1, 32'h200));
    vecs.push_back(mk(0, 0, 32'h140, 0, 32'h0,   0, 32'h0,   32'h100, 0, 32'h104, 0, 32'h144));
    vecs.push_back(mk(0, 0, 32'h140, 0, 32'h0,   0, 32'h0,   32'h140, 1, 32'h200, 0, 32'h144));
    vecs.push_back(mk(1, 0, 32'h140, 0, 32'h0,   1, 32'h200, 32'h140, 1, 32'h200, 1, 32'h144));
    vecs.push_back(mk(0, 0, 32'h140, 1, 32'h300, 1, 32'h200, 32'h140, 1, 32'h200, 0, 32'h300));
    vecs.push_back(mk(1, 0, 32'h140, 1, 32'h200, 1, 32'h200, 32'h140, 1, 32'h200, 0, 32'h200));
    vecs.push_back(mk(1, 0, 32'h180, 0, 32'h0,   0, 32'h184, 32'h140, 1, 32'h200, 0, 32'h184));
    vecs.push_back(mk(0, 0, 32'h180, 0, 32'h0,   0, 32'h0,   32'h180, 0, 32'h184, 0, 32'h184));
    vecs.push_back(mk(0, 0, 32'h180, 0, 32'h0,   0, 32'h0,   32'hFFFFFFFC, 0, 32'h0, 0, 32'h184));
    vecs.push_back(mk(1, 0, 32'h140, 0, 32'h0,   1, 32'h200, 32'h140, 1, 32'h200, 1, 32'h144));
    vecs.push_back(mk(1, 0, 32'h140, 0, 32'h0,   1, 32'h200, 32'h140, 1, 32'h200, 1, 32'h144));
    vecs.push_back(mk(0, 0, 32'h140, 0, 32'h0,   0, 32'h0,   32'h140, 0, 32'h144, 0, 32'h144));

    // Outputs during reset follow the lookup PC
    #2;
    check("rst_pred_taken", {31'b0, pred_taken_f}, 32'h0);
    check("rst_pred_pc", pred_pc_f, 32'h104);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_branch_cnt", {28'b0, branch_cnt}, 32'h0);
    check("rst_mispred_cnt", {28'b0, mispred_cnt}, 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].upd, vecs[i].jmp, vecs[i].pc_e, vecs[i].tkn, vecs[i].tgt,
            vecs[i].ptkn, vecs[i].ppc, vecs[i].pc_f);
      #1;
      check($sformatf("v%0d_pred_taken", i), {31'b0, pred_taken_f}, {31'b0, vecs[i].e_pt});
      check($sformatf("v%0d_pred_pc", i), pred_pc_f, vecs[i].e_ppc);
      check($sformatf("v%0d_mispred", i), {31'b0, mispred_e}, {31'b0, vecs[i].e_mis});
      check($sformatf("v%0d_redirect", i), redirect_pc_e, vecs[i].e_rpc);
      @(negedge clk);
    end
    idle();
    #1;
    check("tbl_branch_cnt", {28'b0, branch_cnt}, 32'd12);
    check("tbl_mispred_cnt", {28'b0, mispred_cnt}, 32'd8);

    // 20 mispredicted not-taken misses: both counters saturate at 15
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 1'b0, 32'h1000, 1'b0, 32'h0, 1'b1, 32'h2000, 32'h100);
      @(negedge clk);
    end
    idle();
    #1;
    check("sat_branch_cnt", {28'b0, branch_cnt}, 32'd15);
    check("sat_mispred_cnt", {28'b0, mispred_cnt}, 32'd15);
    check("miss_no_alloc", {31'b0, pred_taken_f}, 32'h0);

    // Clear wins over a same-cycle increment
    drive(1'b1, 1'b0, 32'h1000, 1'b0, 32'h0, 1'b1, 32'h2000, 32'h100);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    idle();
    #1;
    check("clr_branch_cnt", {28'b0, branch_cnt}, 32'h0);
    check("clr_mispred_cnt", {28'b0, mispred_cnt}, 32'h0);

    drive(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 32'h100);
    @(negedge clk);
    idle();
    #1;
    check("post_clr_branch_cnt", {28'b0, branch_cnt}, 32'h1);
    check("post_clr_mispred_cnt", {28'b0, mispred_cnt}, 32'h1);
    check("jump_pred_taken", {31'b0, pred_taken_f}, 32'h1);
    check("jump_pred_pc", pred_pc_f, 32'h80);

    // Asynchronous reset mid-cycle discards training immediately
    #2;
    rst = 1'b1;
    #1;
    check("midrst_pred_taken", {31'b0, pred_taken_f}, 32'h0);
    check("midrst_pred_pc", pred_pc_f, 32'h104);
    check("midrst_branch_cnt", {28'b0, branch_cnt}, 32'h0);
    check("midrst_mispred_cnt", {28'b0, mispred_cnt}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("postrst_pred_taken", {31'b0, pred_taken_f}, 32'h0);
    check("postrst_pred_pc", pred_pc_f, 32'h104);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
